// File: rtl/sdram_cmd_sched.sv
// SDRAM command scheduler: arbitrates host accesses against periodic auto-refresh and
// sequences ACT / RD-WR / PRE / REF with programmable NOP gaps (closed-page policy).
module sdram_cmd_sched #(
    parameter int REF_INTERVAL = 1560,
    parameter int REF_W        = 11
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] t_rcd,
    input  logic [3:0] t_rp,
    input  logic [3:0] t_rfc,
    input  logic [3:0] burst_len,
    input  logic       host_req,
    input  logic       host_wr,
    output logic       host_ack,
    output logic [2:0] cmd,
    output logic       data_phase,
    output logic       ref_pending,
    output logic       busy,
    output logic [3:0] state_dbg
);

    // Handshake: host_req is held high (with host_wr stable) until host_ack pulses for
    // one cycle in the READ/WRITE command cycle; the request is accepted in IDLE only.

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ACT   = 4'd1,
        S_W_RCD = 4'd2,
        S_RW    = 4'd3,
        S_DATA  = 4'd4,
        S_PRE   = 4'd5,
        S_W_RP  = 4'd6,
        S_REF   = 4'd7,
        S_W_RFC = 4'd8
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             op_wr;
    logic [3:0]       wait_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic             ref_wrap;
    logic             wait_done;

    assign ref_wrap  = (ref_cnt == REF_W'(REF_INTERVAL - 1));
    // A loaded value of 0 still yields one wait cycle.
    assign wait_done = (wait_cnt <= 4'd1);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ref_pending)   state_nxt = S_REF;
                else if (host_req) state_nxt = S_ACT;
            end
            S_ACT:   state_nxt = S_W_RCD;
            S_W_RCD: if (wait_done) state_nxt = S_RW;
            S_RW:    state_nxt = S_DATA;
            S_DATA:  if (wait_done) state_nxt = S_PRE;
            S_PRE:   state_nxt = S_W_RP;
            S_W_RP:  if (wait_done) state_nxt = S_IDLE;
            S_REF:   state_nxt = S_W_RFC;
            S_W_RFC: if (wait_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            op_wr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && !ref_pending && host_req)
                op_wr <= host_wr;
        end
    end

    // Timing inputs are captured only in the command cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                S_ACT:   wait_cnt <= t_rcd;
                S_RW:    wait_cnt <= burst_len;
                S_PRE:   wait_cnt <= t_rp;
                S_REF:   wait_cnt <= t_rfc;
                S_W_RCD, S_DATA, S_W_RP, S_W_RFC:
                         wait_cnt <= (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;
                default: wait_cnt <= wait_cnt;
            endcase
        end
    end

    // A wrap landing on the REF cycle re-arms the request rather than losing it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
            if (ref_wrap)
                ref_pending <= 1'b1;
            else if (state == S_REF)
                ref_pending <= 1'b0;
        end
    end

    always_comb begin
        cmd        = CMD_NOP;
        host_ack   = 1'b0;
        data_phase = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_ACT: cmd = CMD_ACT;
            S_RW: begin
                cmd      = op_wr ? CMD_WR : CMD_RD;
                host_ack = 1'b1;
            end
            S_DATA:  data_phase = 1'b1;
            S_PRE:   cmd = CMD_PRE;
            S_REF:   cmd = CMD_REF;
            default: cmd = CMD_NOP;
        endcase
    end

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Bench for sdram_cmd_sched: a per-cycle vector table for access sequences on the
// default refresh interval, plus hand sequences for refresh timing on a short interval.
module tb_sdram_cmd_sched;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] t_rcd, t_rp, t_rfc, burst_len;
    logic       host_req, host_wr;

    logic       host_ack, data_phase, ref_pending, busy;
    logic [2:0] cmd;
    logic [3:0] state_dbg;

    logic       d16_ack, d16_dp, d16_rp, d16_busy;
    logic [2:0] d16_cmd;
    logic [3:0] d16_state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sdram_cmd_sched #(.REF_INTERVAL(1560), .REF_W(11)) dut (
        .Clk(Clk), .Reset(Reset), .t_rcd(t_rcd), .t_rp(t_rp), .t_rfc(t_rfc),
        .burst_len(burst_len), .host_req(host_req), .host_wr(host_wr),
        .host_ack(host_ack), .cmd(cmd), .data_phase(data_phase),
        .ref_pending(ref_pending), .busy(busy), .state_dbg(state_dbg)
    );

    sdram_cmd_sched #(.REF_INTERVAL(16), .REF_W(5)) dut16 (
        .Clk(Clk), .Reset(Reset), .t_rcd(t_rcd), .t_rp(t_rp), .t_rfc(t_rfc),
        .burst_len(burst_len), .host_req(host_req), .host_wr(host_wr),
        .host_ack(d16_ack), .cmd(d16_cmd), .data_phase(d16_dp),
        .ref_pending(d16_rp), .busy(d16_busy), .state_dbg(d16_state_dbg)
    );

    // tim packs {t_rcd, burst_len, t_rp, t_rfc}
    typedef struct {
        logic        rst;
        logic        req;
        logic        wr;
        logic [15:0] tim;
        logic [2:0]  cmd;
        logic        ack;
        logic        dp;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic req, input logic wr,
                       input logic [15:0] tim, input logic [2:0] c,
                       input logic ack, input logic dp, input logic bsy, input int n);
        vec_t v;
        v.rst = rst; v.req = req; v.wr = wr; v.tim = tim;
        v.cmd = c; v.ack = ack; v.dp = dp; v.busy = bsy;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int          c;
        logic [2:0]  e_cmd;
        logic        e_rp, e_busy;

        Reset = 1'b1; host_req = 1'b0; host_wr = 1'b0;
        {t_rcd, burst_len, t_rp, t_rfc} = 16'h2427;
        tick();
        tick();
        check("rst_cmd", 32'(cmd), 0);
        check("rst_ack", 32'(host_ack), 0);
        check("rst_dp", 32'(data_phase), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rp", 32'(ref_pending), 0);
        check("rst_state", 32'(state_dbg), 0);
        check("rst16_state", 32'(d16_state_dbg), 0);

        // Read t_rcd=2 bl=4 t_rp=2, request at cycle 10
        add(0, 0, 0, 16'h2427, 0, 0, 0, 0, 10);
        add(0, 1, 0, 16'h2427, 0, 0, 0, 0, 1);
        add(0, 1, 0, 16'h2427, 1, 0, 0, 1, 1);
        add(0, 1, 0, 16'h2427, 0, 0, 0, 1, 2);
        add(0, 1, 0, 16'h2427, 2, 1, 0, 1, 1);
        add(0, 0, 0, 16'h2427, 0, 0, 1, 1, 4);
        add(0, 0, 0, 16'h2427, 4, 0, 0, 1, 1);
        add(0, 0, 0, 16'h2427, 0, 0, 0, 1, 2);
        add(0, 0, 0, 16'h2427, 0, 0, 0, 0, 2);
        // Write with all timings 0; host_wr flips after acceptance
        add(0, 1, 1, 16'h0000, 0, 0, 0, 0, 1);
        add(0, 1, 0, 16'h0000, 1, 0, 0, 1, 1);
        add(0, 1, 0, 16'h0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 16'h0000, 3, 1, 0, 1, 1);
        add(0, 0, 0, 16'h0000, 0, 0, 1, 1, 1);
        add(0, 0, 0, 16'h0000, 4, 0, 0, 1, 1);
        add(0, 0, 0, 16'h0000, 0, 0, 0, 1, 1);
        add(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
        // t_rcd=3 captured in ACT then changed; request held for back-to-back
        add(0, 1, 0, 16'h3217, 0, 0, 0, 0, 1);
        add(0, 1, 0, 16'h3217, 1, 0, 0, 1, 1);
        add(0, 1, 0, 16'h0217, 0, 0, 0, 1, 3);
        add(0, 1, 0, 16'h0217, 2, 1, 0, 1, 1);
        add(0, 1, 0, 16'h0217, 0, 0, 1, 1, 2);
        add(0, 1, 0, 16'h0217, 4, 0, 0, 1, 1);
        add(0, 1, 0, 16'h0217, 0, 0, 0, 1, 1);
        add(0, 1, 0, 16'h0217, 0, 0, 0, 0, 1);
        add(0, 1, 0, 16'h0217, 1, 0, 0, 1, 1);
        add(0, 0, 0, 16'h0217, 0, 0, 0, 1, 1);
        add(0, 0, 0, 16'h0217, 2, 1, 0, 1, 1);
        add(0, 0, 0, 16'h0217, 0, 0, 1, 1, 2);
        add(0, 0, 0, 16'h0217, 4, 0, 0, 1, 1);
        add(0, 0, 0, 16'h0217, 0, 0, 0, 1, 1);
        add(0, 0, 0, 16'h0217, 0, 0, 0, 0, 1);
        // Reset pulse during W_RCD with request held
        add(0, 1, 0, 16'h3117, 0, 0, 0, 0, 1);
        add(0, 1, 0, 16'h3117, 1, 0, 0, 1, 1);
        add(1, 1, 0, 16'h3117, 0, 0, 0, 1, 1);
        add(0, 1, 0, 16'h3117, 0, 0, 0, 0, 1);
        add(0, 1, 0, 16'h3117, 1, 0, 0, 1, 1);
        add(0, 1, 0, 16'h3117, 0, 0, 0, 1, 3);
        add(0, 1, 0, 16'h3117, 2, 1, 0, 1, 1);
        add(0, 0, 0, 16'h3117, 0, 0, 1, 1, 1);
        add(0, 0, 0, 16'h3117, 4, 0, 0, 1, 1);
        add(0, 0, 0, 16'h3117, 0, 0, 0, 1, 1);
        add(0, 0, 0, 16'h3117, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            Reset    = vecs[i].rst;
            host_req = vecs[i].req;
            host_wr  = vecs[i].wr;
            {t_rcd, burst_len, t_rp, t_rfc} = vecs[i].tim;
            check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].cmd));
            check($sformatf("v%0d_ack", i), 32'(host_ack), 32'(vecs[i].ack));
            check($sformatf("v%0d_dp", i), 32'(data_phase), 32'(vecs[i].dp));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d_rp", i), 32'(ref_pending), 0);
            tick();
        end

        // First refresh on the default interval
        Reset = 1'b1; host_req = 1'b0;
        {t_rcd, burst_len, t_rp, t_rfc} = 16'h2427;
        tick();
        Reset = 1'b0;
        c = 0;
        while (!ref_pending && c < 2000) begin
            tick();
            c++;
        end
        check("ref_first_cycle", 32'(c), 1560);
        tick();
        check("ref_cmd", 32'(cmd), 5);
        check("ref_busy", 32'(busy), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("rfc%0d_cmd", i), 32'(cmd), 0);
            check($sformatf("rfc%0d_busy", i), 32'(busy), 1);
            check($sformatf("rfc%0d_rp", i), 32'(ref_pending), 0);
        end
        tick();
        check("rfc_end_busy", 32'(busy), 0);
        check("rfc_end_rp", 32'(ref_pending), 0);

        // Short interval: refresh priority, wrap during access, wrap on REF cycle
        Reset = 1'b1; host_req = 1'b0; host_wr = 1'b0;
        {t_rcd, burst_len, t_rp, t_rfc} = 16'h4F32;
        tick();
        Reset = 1'b0;
        for (int cyc = 0; cyc <= 54; cyc++) begin
            host_req = (cyc >= 16 && cyc <= 26);
            case (cyc)
                17, 47, 51: e_cmd = 3'd5;
                21:         e_cmd = 3'd1;
                26:         e_cmd = 3'd2;
                42:         e_cmd = 3'd4;
                default:    e_cmd = 3'd0;
            endcase
            e_rp   = (cyc == 16 || cyc == 17 || (cyc >= 32 && cyc <= 51));
            e_busy = !(cyc <= 16 || cyc == 20 || cyc == 46 || cyc == 50 || cyc == 54);
            check($sformatf("d16_cmd@%0d", cyc), 32'(d16_cmd), 32'(e_cmd));
            check($sformatf("d16_ack@%0d", cyc), 32'(d16_ack), 32'(cyc == 26));
            check($sformatf("d16_dp@%0d", cyc), 32'(d16_dp), 32'(cyc >= 27 && cyc <= 41));
            check($sformatf("d16_rp@%0d", cyc), 32'(d16_rp), 32'(e_rp));
            check($sformatf("d16_busy@%0d", cyc), 32'(d16_busy), 32'(e_busy));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
